// File: rtl/axis_image_scaler_arbiter.sv
// Packet-granular round-robin arbiter feeding one image-to-tensor scaler.
// Forwards the granted stream unchanged; truncates overlong packets and drains the remainder.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no grant active; pick next requester after last_grant
// FORWARD | granted port's beats pass straight through to the scaler
// DRAIN   | packet truncated; accept and discard until source tlast
module axis_image_scaler_arbiter #(
    parameter int TDATA_WIDTH    = 64,
    parameter int TKEEP_WIDTH    = TDATA_WIDTH / 8,
    parameter int TUSER_WIDTH    = 128,
    parameter int NUM_PORTS      = 4,
    parameter int MAX_BEATS      = 256,
    parameter int PORT_IDX_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                               axis_aclk,
    input  logic                               axis_reset,
    input  logic [NUM_PORTS*TDATA_WIDTH-1:0]   s_axis_image_tdata,
    input  logic [NUM_PORTS*TKEEP_WIDTH-1:0]   s_axis_image_tkeep,
    input  logic [NUM_PORTS*TUSER_WIDTH-1:0]   s_axis_image_tuser,
    input  logic [NUM_PORTS-1:0]               s_axis_image_tvalid,
    output logic [NUM_PORTS-1:0]               s_axis_image_tready,
    input  logic [NUM_PORTS-1:0]               s_axis_image_tlast,
    output logic [TDATA_WIDTH-1:0]             m_axis_image_tdata,
    output logic [TKEEP_WIDTH-1:0]             m_axis_image_tkeep,
    output logic [TUSER_WIDTH-1:0]             m_axis_image_tuser,
    output logic                               m_axis_image_tvalid,
    input  logic                               m_axis_image_tready,
    output logic                               m_axis_image_tlast,
    output logic [PORT_IDX_WIDTH-1:0]          grant_index,
    output logic                               truncate_pulse,
    output logic [15:0]                        truncate_count
);

    localparam int                   CNT_WIDTH = $clog2(MAX_BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FORWARD,
        ST_DRAIN
    } state_t;

    state_t                    r_state;
    logic [PORT_IDX_WIDTH-1:0] r_grant;
    logic [PORT_IDX_WIDTH-1:0] r_last_grant;
    logic [CNT_WIDTH-1:0]      r_beat_cnt;
    logic                      r_trunc_pulse;
    logic [15:0]               r_trunc_count;

    logic [TDATA_WIDTH-1:0]    w_sel_data;
    logic [TKEEP_WIDTH-1:0]    w_sel_keep;
    logic [TUSER_WIDTH-1:0]    w_sel_user;
    logic                      w_sel_valid;
    logic                      w_sel_last;
    logic                      w_handshake;
    logic                      w_force_last;
    logic                      w_arb_found;
    logic [PORT_IDX_WIDTH-1:0] w_arb_port;

    always_comb begin
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_user  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == PORT_IDX_WIDTH'(p)) begin
                w_sel_data  = s_axis_image_tdata[p*TDATA_WIDTH +: TDATA_WIDTH];
                w_sel_keep  = s_axis_image_tkeep[p*TKEEP_WIDTH +: TKEEP_WIDTH];
                w_sel_user  = s_axis_image_tuser[p*TUSER_WIDTH +: TUSER_WIDTH];
                w_sel_valid = s_axis_image_tvalid[p];
                w_sel_last  = s_axis_image_tlast[p];
            end
        end
    end

    // Rotating priority: lowest requester above last_grant wins, else lowest at or below it.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_port  = r_last_grant;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (s_axis_image_tvalid[p] && (PORT_IDX_WIDTH'(p) <= r_last_grant)) begin
                w_arb_found = 1'b1;
                w_arb_port  = PORT_IDX_WIDTH'(p);
            end
        end
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (s_axis_image_tvalid[p] && (PORT_IDX_WIDTH'(p) > r_last_grant)) begin
                w_arb_found = 1'b1;
                w_arb_port  = PORT_IDX_WIDTH'(p);
            end
        end
    end

    assign w_handshake  = (r_state == ST_FORWARD) && w_sel_valid && m_axis_image_tready;
    assign w_force_last = (r_state == ST_FORWARD) && (r_beat_cnt == LAST_CNT);

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_last_grant  <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
            r_beat_cnt    <= '0;
            r_trunc_pulse <= 1'b0;
            r_trunc_count <= '0;
        end else begin
            r_trunc_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_found) begin
                        r_grant <= w_arb_port;
                        r_state <= ST_FORWARD;
                    end
                end
                ST_FORWARD: begin
                    if (w_handshake) begin
                        if (w_sel_last) begin
                            r_beat_cnt   <= '0;
                            r_last_grant <= r_grant;
                            r_state      <= ST_IDLE;
                        end else if (r_beat_cnt == LAST_CNT) begin
                            r_beat_cnt    <= '0;
                            r_trunc_pulse <= 1'b1;
                            if (r_trunc_count != 16'hFFFF) begin
                                r_trunc_count <= r_trunc_count + 16'd1;
                            end
                            r_state       <= ST_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_sel_valid && w_sel_last) begin
                        r_last_grant <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_axis_image_tready = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == PORT_IDX_WIDTH'(p)) begin
                s_axis_image_tready[p] = ((r_state == ST_FORWARD) && m_axis_image_tready) ||
                                         (r_state == ST_DRAIN);
            end
        end
    end

    assign m_axis_image_tdata  = w_sel_data;
    assign m_axis_image_tkeep  = w_sel_keep;
    assign m_axis_image_tuser  = w_sel_user;
    assign m_axis_image_tvalid = (r_state == ST_FORWARD) && w_sel_valid;
    assign m_axis_image_tlast  = (r_state == ST_FORWARD) && (w_sel_last || w_force_last);
    assign grant_index         = r_grant;
    assign truncate_pulse      = r_trunc_pulse;
    assign truncate_count      = r_trunc_count;

endmodule

// File: tb/tb_axis_image_scaler_arbiter.sv
// Bench for axis_image_scaler_arbiter: packet sources per port checked against a
// packet-level round-robin/truncation model of the expected output stream.
module tb_axis_image_scaler_arbiter;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int UW = 8;
    localparam int NP = 4;
    localparam int MB = 4;
    localparam int PW = 2;
    localparam int MAXPKT = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            cyc;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP*UW-1:0]  s_tuser;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP-1:0]     s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [PW-1:0]     grant_index;
    logic              truncate_pulse;
    logic [15:0]       truncate_count;

    axis_image_scaler_arbiter #(
        .TDATA_WIDTH(DW), .TKEEP_WIDTH(KW), .TUSER_WIDTH(UW),
        .NUM_PORTS(NP), .MAX_BEATS(MB), .PORT_IDX_WIDTH(PW)
    ) dut (
        .axis_aclk           (clk),
        .axis_reset          (rst),
        .s_axis_image_tdata  (s_tdata),
        .s_axis_image_tkeep  (s_tkeep),
        .s_axis_image_tuser  (s_tuser),
        .s_axis_image_tvalid (s_tvalid),
        .s_axis_image_tready (s_tready),
        .s_axis_image_tlast  (s_tlast),
        .m_axis_image_tdata  (m_tdata),
        .m_axis_image_tkeep  (m_tkeep),
        .m_axis_image_tuser  (m_tuser),
        .m_axis_image_tvalid (m_tvalid),
        .m_axis_image_tready (m_tready),
        .m_axis_image_tlast  (m_tlast),
        .grant_index         (grant_index),
        .truncate_pulse      (truncate_pulse),
        .truncate_count      (truncate_count)
    );

    always #5 clk = ~clk;

    int    plen [NP][MAXPKT];
    int    pid  [NP][MAXPKT];
    int    npkt [NP];
    int    pidx [NP];
    int    bidx [NP];
    bit    held [NP];
    int    serial = 1;
    int    model_last = NP - 1;
    int    exp_trunc_total = 0;
    int    run_trunc = 0;
    beat_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    out_n;
    int    pulses;

    function automatic beat_t mk_beat(int id, int p, int b, int len);
        beat_t r;
        r.d   = {8'(p), 8'(id), 16'(b)};
        r.k   = KW'(b + 3 * p + id);
        r.u   = UW'(id * 5 + b);
        r.l   = (b == len - 1);
        r.cyc = 0;
        return r;
    endfunction

    task automatic sources_idle();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
    endtask

    task automatic clear_sources();
        for (int p = 0; p < NP; p++) begin
            npkt[p] = 0;
            pidx[p] = 0;
            bidx[p] = 0;
            held[p] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic add_pkt(input int p, input int len);
        plen[p][npkt[p]] = len;
        pid[p][npkt[p]]  = serial;
        serial++;
        npkt[p]++;
    endtask

    // Packet-level model: rotate from the last served port, cut each packet at MB beats.
    // Expected cycle assumes sources always valid and sink always ready.
    task automatic build_expected();
        int nxt [NP];
        int t = 1;
        int found;
        int len;
        int f;
        int q;
        beat_t b;
        run_trunc = 0;
        for (int p = 0; p < NP; p++) nxt[p] = pidx[p];
        while (1) begin
            found = -1;
            for (int i = 1; i <= NP; i++) begin
                q = (model_last + i) % NP;
                if (found < 0 && nxt[q] < npkt[q]) found = q;
            end
            if (found < 0) break;
            len = plen[found][nxt[found]];
            f   = (len > MB) ? MB : len;
            for (int i = 0; i < f; i++) begin
                b     = mk_beat(pid[found][nxt[found]], found, i, len);
                b.l   = (i == f - 1);
                b.cyc = t + i;
                exp_q.push_back(b);
            end
            if (len > MB) run_trunc++;
            t = t + f + ((len > MB) ? (len - MB) : 0) + 1;
            model_last = found;
            nxt[found]++;
        end
        exp_trunc_total += run_trunc;
    endtask

    task automatic run_traffic(input int max_cyc, input int gap_pct, input int rmode,
                               input bit timed, input int stop_after);
        int          cyc = 0;
        bit          done;
        bit          stopped = 1'b0;
        logic [NP-1:0] v;
        beat_t       b;
        beat_t       e;
        out_n  = 0;
        pulses = 0;
        while (1) begin
            done = (exp_q.size() == 0);
            for (int p = 0; p < NP; p++) if (pidx[p] < npkt[p]) done = 1'b0;
            if (done) break;
            if (stop_after > 0 && out_n >= stop_after) begin
                stopped = 1'b1;
                break;
            end
            if (cyc >= max_cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
                break;
            end
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (pidx[p] < npkt[p]) begin
                    if (bidx[p] == 0 || held[p]) v[p] = 1'b1;
                    else v[p] = ($urandom_range(0, 99) >= gap_pct);
                    b = mk_beat(pid[p][pidx[p]], p, bidx[p], plen[p][pidx[p]]);
                    s_tdata[p*DW +: DW] = b.d;
                    s_tkeep[p*KW +: KW] = b.k;
                    s_tuser[p*UW +: UW] = b.u;
                    s_tlast[p]          = b.l;
                end else begin
                    v[p]       = 1'b0;
                    s_tlast[p] = 1'b0;
                end
            end
            s_tvalid = v;
            if (rmode == 0)      m_tready = 1'b1;
            else if (rmode == 1) m_tready = ((cyc % 2) == 1);
            else                 m_tready = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if ($countones(s_tready) > 1) begin
                miscompares++;
                $display("FAIL ready_onehot: s_tready=%b at cycle %0d, required at most one bit", s_tready, cyc);
            end
            if (m_tvalid) begin
                vectors++;
                if ((|s_tready) !== m_tready || (s_tready & ~v) !== '0) begin
                    miscompares++;
                    $display("FAIL ready_mirror: s_tready=%b with m_tready=%b valid=%b at cycle %0d",
                             s_tready, m_tready, v, cyc);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_beat: d=%h at cycle %0d, required no beat", m_tdata, cyc);
                end else begin
                    e = exp_q[0];
                    if ({m_tdata, m_tkeep, m_tuser, m_tlast} !== {e.d, e.k, e.u, e.l}) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h k=%h u=%h l=%b, required d=%h k=%h u=%h l=%b",
                                 m_tdata, m_tkeep, m_tuser, m_tlast, e.d, e.k, e.u, e.l);
                    end
                    if (timed) begin
                        vectors++;
                        if (cyc !== e.cyc) begin
                            miscompares++;
                            $display("FAIL beat_cycle: d=%h at cycle %0d, required cycle %0d", e.d, cyc, e.cyc);
                        end
                    end
                    if (m_tready) begin
                        void'(exp_q.pop_front());
                        out_n++;
                    end
                end
            end
            if (truncate_pulse) pulses++;
            for (int p = 0; p < NP; p++) begin
                if (v[p] && s_tready[p]) begin
                    held[p] = 1'b0;
                    bidx[p]++;
                    if (bidx[p] == plen[p][pidx[p]]) begin
                        bidx[p] = 0;
                        pidx[p]++;
                    end
                end else begin
                    held[p] = v[p];
                end
            end
            cyc++;
        end
        if (!stopped) begin
            @(negedge clk);
            sources_idle();
            m_tready = 1'b1;
            #1;
            if (truncate_pulse) pulses++;
            vectors++;
            if (m_tvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_after: m_tvalid=%b after traffic, required 0", m_tvalid);
            end
            vectors++;
            if (pulses !== run_trunc) begin
                miscompares++;
                $display("FAIL trunc_pulses: got %0d pulses, required %0d", pulses, run_trunc);
            end
            vectors++;
            if (truncate_count !== 16'(exp_trunc_total)) begin
                miscompares++;
                $display("FAIL trunc_count: got %0d, required %0d", truncate_count, exp_trunc_total);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        sources_idle();
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_sources();
        model_last      = NP - 1;
        exp_trunc_total = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        sources_idle();
        m_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({s_tready, m_tvalid, m_tlast, grant_index, truncate_pulse, truncate_count} !==
            {4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b mv=%b ml=%b g=%0d tp=%b tc=%0d, required all zero",
                     s_tready, m_tvalid, m_tlast, grant_index, truncate_pulse, truncate_count);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_sources();
        model_last      = NP - 1;
        exp_trunc_total = 0;
    endtask

    task automatic test_single_packet();
        clear_sources();
        add_pkt(2, 3);
        build_expected();
        run_traffic(50, 0, 0, 1'b1, 0);
        vectors++;
        if (grant_index !== 2'd2) begin
            miscompares++;
            $display("FAIL single_grant: grant_index=%0d, required 2", grant_index);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            add_pkt(0, 2);
            add_pkt(1, 2);
            add_pkt(3, 2);
        end
        build_expected();
        run_traffic(100, 0, 0, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        clear_sources();
        add_pkt(1, 4);
        build_expected();
        run_traffic(100, 0, 1, 1'b0, 0);
        vectors++;
        if (out_n !== 4) begin
            miscompares++;
            $display("FAIL bp_beats: forwarded %0d beats, required 4", out_n);
        end
    endtask

    task automatic test_truncation();
        clear_sources();
        add_pkt(0, 7);
        add_pkt(1, 2);
        build_expected();
        run_traffic(100, 0, 0, 1'b1, 0);
    endtask

    task automatic test_exact_length();
        clear_sources();
        add_pkt(0, 4);
        add_pkt(1, 1);
        build_expected();
        run_traffic(100, 0, 0, 1'b1, 0);
    endtask

    task automatic test_reset_mid_packet();
        clear_sources();
        add_pkt(3, 5);
        build_expected();
        run_traffic(50, 0, 0, 1'b1, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({s_tready, m_tvalid, m_tlast, grant_index, truncate_pulse, truncate_count} !==
            {4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 16'd0}) begin
            miscompares++;
            $display("FAIL midreset_values: ready=%b mv=%b ml=%b g=%0d tp=%b tc=%0d, required all zero",
                     s_tready, m_tvalid, m_tlast, grant_index, truncate_pulse, truncate_count);
        end
        @(negedge clk);
        rst = 1'b0;
        sources_idle();
        clear_sources();
        model_last      = NP - 1;
        exp_trunc_total = 0;
        add_pkt(3, 3);
        add_pkt(0, 2);
        build_expected();
        run_traffic(100, 0, 0, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear_sources();
            for (int p = 0; p < NP; p++) begin
                int n = $urandom_range(0, 3);
                for (int i = 0; i < n; i++) add_pkt(p, $urandom_range(1, 7));
            end
            build_expected();
            run_traffic(2000, 30, 2, 1'b0, 0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        m_tready = 1'b0;
        sources_idle();
        clear_sources();
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_truncation();
        test_exact_length();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axis_image_scaler_arbiter.md
# axis_image_scaler_arbiter

Packet-granular round-robin arbiter that lets NUM_PORTS independent AXI-Stream image streams share a single image-to-tensor scaler instance. It sits directly upstream of the scaler. It holds a grant for a whole packet and forwards the granted stream's beats unchanged. It also enforces a maximum packet length: an overlong packet is truncated with a forced tlast, and the rest of it is drained and discarded.

## Interface

**Parameters**
- TDATA_WIDTH, 64: image-side data width (the scaler's small width).
- TKEEP_WIDTH, TDATA_WIDTH/8: derived.
- TUSER_WIDTH, 128: sideband width, passed through untouched.
- NUM_PORTS, 4: number of requesters, ≥2.
- MAX_BEATS, 256: maximum beats forwarded per packet, ≥2.
- PORT_IDX_WIDTH, clog2(NUM_PORTS): derived.

**Ports**
- axis_aclk, in, 1: the single clock.
- axis_reset, in, 1: synchronous, active-high reset.
- s_axis_image_tdata, in, NUM_PORTS*TDATA_WIDTH: flattened; port p occupies slice [p*TDATA_WIDTH +: TDATA_WIDTH].
- s_axis_image_tkeep, in, NUM_PORTS*TKEEP_WIDTH: flattened, same slicing rule.
- s_axis_image_tuser, in, NUM_PORTS*TUSER_WIDTH: flattened, same slicing rule.
- s_axis_image_tvalid, in, NUM_PORTS: per-port valid.
- s_axis_image_tready, out, NUM_PORTS: per-port ready.
- s_axis_image_tlast, in, NUM_PORTS: per-port last.
- m_axis_image_tdata / tkeep / tuser, out, TDATA_WIDTH / TKEEP_WIDTH / TUSER_WIDTH: to the scaler.
- m_axis_image_tvalid, out, 1.
- m_axis_image_tready, in, 1.
- m_axis_image_tlast, out, 1.
- grant_index, out, PORT_IDX_WIDTH: currently or most recently granted port.
- truncate_pulse, out, 1: one-cycle pulse on each truncation.
- truncate_count, out, 16: saturating count of truncations.

## Operation

**State machine** (registered state: IDLE, FORWARD, DRAIN)
- IDLE
  - m_tvalid = 0; all s_tready = 0.
  - If any s_tvalid is 1: register grant = the first requesting port searching upward (with wrap) from last_grant+1. Next state is FORWARD.
- FORWARD
  - m_tdata/tkeep/tuser/tvalid = the granted port's slice (combinational mux).
  - m_tlast = s_tlast[g] OR force_last.
  - s_tready[g] = m_tready; s_tready of all other ports = 0.
  - A handshake is s_tvalid[g] & m_tready.
  - beat_cnt increments on each handshake.
  - Handshake with s_tlast[g] = 1: beat_cnt ← 0, last_grant ← g, next state IDLE.
  - Otherwise, a handshake with beat_cnt == MAX_BEATS-1:
    - force_last is asserted on that beat, so m_tlast = 1.
    - truncate_pulse = 1 next cycle; truncate_count increments (saturates at 0xFFFF).
    - beat_cnt ← 0, next state DRAIN.
- DRAIN
  - m_tvalid = 0; s_tready[g] = 1; other ports' ready = 0.
  - Drained beats are discarded.
  - On s_tvalid[g] & s_tlast[g]: last_grant ← g, next state IDLE.

**Rules**
- A packet whose tlast lands exactly on beat MAX_BEATS is not a truncation: its tlast is natural, no pulse, no DRAIN.
- tdata, tkeep and tuser are never modified. Only tlast can be forced.
- When m_tvalid = 0, the m_axis data outputs are don't-care; the bench must not check them.
- grant_index = the registered grant. It holds its value through IDLE.
- A port whose tvalid drops mid-packet keeps the grant. There is no timeout.

## Timing

- **Reset** (while axis_reset = 1; takes effect at the clock edge):
  - state = IDLE; grant = 0; last_grant = NUM_PORTS-1, so port 0 wins first.
  - beat_cnt = 0; truncate_count = 0; truncate_pulse = 0.
  - All s_tready = 0; m_tvalid = 0; m_tlast = 0.
- **Reset mid-packet:** the packet is abandoned and no tlast is emitted. Downstream is reset in the same domain.
- **Arbitration latency:**
  - One-cycle bubble. A request seen in IDLE at cycle N gives the first forwarded beat at cycle N+1 at the earliest.
  - A packet ending at cycle N means IDLE at N+1 and the next packet starts at N+2.
- **Datapath latency:** zero cycles (combinational pass-through, no buffering). Throughput is 1 beat/cycle within a packet.
- **AXIS compliance:** a valid with no ready must hold. The arbiter never deasserts m_tvalid mid-beat unless the source does.

## Test plan

- **Single packet:** port 2 sends 3 beats D0–D2, tlast on D2, m_tready = 1 throughout.
  - m sees D0, D1, D2 with tlast on D2; grant_index = 2.
  - First m_tvalid appears 1 cycle after the request; state is IDLE the cycle after D2.
- **Round-robin:** ports 0, 1 and 3 all request with 2-beat packets continuously from reset.
  - Grant order is 0, 1, 3, 0, 1, 3.
  - No interleaving within a packet; exactly 1 idle cycle between packets.
- **Backpressure:** m_tready toggles 1,0,1,0 during a 4-beat packet on port 1.
  - s_tready[1] mirrors m_tready; no beat is lost or duplicated.
  - s_tready of every other port stays 0.
- **Truncation:** MAX_BEATS = 4; port 0 sends a 7-beat packet.
  - m sees 4 beats with tlast forced on beat 4; truncate_pulse asserts once; truncate_count = 1.
  - Beats 5–7 are accepted with m_tvalid = 0; the next grant happens afterwards.
- **Exact-length packet:** MAX_BEATS = 4; a 4-beat packet with tlast on beat 4.
  - No pulse; truncate_count is unchanged; no DRAIN cycles.
- **Reset mid-packet:** assert axis_reset after beat 2 of a 5-beat packet on port 3.
  - Outputs take reset values at the next edge.
  - After release, with ports 0 and 3 both requesting, port 0 is granted first.
